// File: rtl/byte_encode_stream_if.sv
// rtl/byte_encode_stream_if.sv - coefficient-in / packed-byte-out stream bundle
// slave is the packer's view, master is the producer/sink side.
interface byte_encode_stream_if;
  logic        coef_valid;
  logic        coef_ready;
  logic [15:0] coef_data;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        byte_last;

  modport slave (
    input  coef_valid, coef_data, byte_ready,
    output coef_ready, byte_valid, byte_data, byte_last
  );

  modport master (
    output coef_valid, coef_data, byte_ready,
    input  coef_ready, byte_valid, byte_data, byte_last
  );
endinterface

// File: rtl/byte_encode_stream.sv
// rtl/byte_encode_stream.sv - streaming ByteEncode_d packer
// Packs the low D bits of each coefficient LSB-first and emits one byte per handshake.
module byte_encode_stream #(
  parameter int D      = 12,
  parameter int NCOEF  = 256,
  parameter int REDUCE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  byte_encode_stream_if.slave  s,
  output logic                 busy
);
  localparam int ACCW   = 24;
  localparam int NBYTES = NCOEF * D / 8;
  localparam int CIDXW  = (NCOEF > 1) ? $clog2(NCOEF) : 1;
  localparam int BIDXW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam bit REDUCE_EN = (REDUCE != 0) && (D == 12);
  localparam logic [15:0] Q = 16'd3329;

  logic [ACCW-1:0]  r_acc;
  logic [4:0]       r_cnt;
  logic [CIDXW-1:0] r_cidx;
  logic [BIDXW-1:0] r_bidx;

  logic             w_coef_ready;
  logic             w_byte_valid;
  logic             w_byte_last;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [15:0]      w_addend;
  logic [D-1:0]     w_pack;
  logic [4:0]       w_base;
  logic [ACCW-1:0]  w_acc_next;
  logic [4:0]       w_cnt_next;

  // Both handshake qualifiers come from registered cnt only, so byte_ready never reaches coef_ready.
  assign w_coef_ready = ({1'b0, r_cnt} + 6'(D)) <= 6'(ACCW);
  assign w_byte_valid = (r_cnt >= 5'd8);
  assign w_byte_last  = w_byte_valid && (r_bidx == BIDXW'(NBYTES - 1));

  assign s.coef_ready = w_coef_ready;
  assign s.byte_valid = w_byte_valid;
  assign s.byte_data  = r_acc[7:0];
  assign s.byte_last  = w_byte_last;
  assign busy         = (r_cnt != 5'd0) || (r_cidx != '0);

  assign w_in_fire  = s.coef_valid && w_coef_ready;
  assign w_out_fire = w_byte_valid && s.byte_ready;

  // ByteEncode_12 keys: negative coefficients are lifted into [0, q) before truncation.
  assign w_addend = (REDUCE_EN && s.coef_data[15]) ? Q : 16'd0;
  assign w_pack   = D'(s.coef_data + w_addend);

  // New bits land just above whatever survives this cycle's byte pop.
  assign w_base = w_out_fire ? (r_cnt - 5'd8) : r_cnt;

  always_comb begin
    w_acc_next = w_out_fire ? (r_acc >> 8) : r_acc;
    if (w_in_fire) begin
      w_acc_next = w_acc_next | (ACCW'(w_pack) << w_base);
    end
    w_cnt_next = w_base + (w_in_fire ? 5'(D) : 5'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_acc  <= '0;
      r_cnt  <= 5'd0;
      r_cidx <= '0;
      r_bidx <= '0;
    end else begin
      r_acc <= w_acc_next;
      r_cnt <= w_cnt_next;
      if (w_in_fire) begin
        r_cidx <= (r_cidx == CIDXW'(NCOEF - 1)) ? '0 : r_cidx + CIDXW'(1);
      end
      if (w_out_fire) begin
        r_bidx <= w_byte_last ? '0 : r_bidx + BIDXW'(1);
      end
    end
  end
endmodule
